// File: rtl/pipelined_addsub_unit.sv
// Pipelined carry-lookahead add/subtract unit with condition flags.
// The carry chain is cut into STAGES equal slices; slice s is resolved in
// pipeline stage s, with its carry-out registered into the next stage.
// A single global advance signal stalls every stage together under backpressure.
module pipelined_addsub_unit #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             v_out,
  output logic             z_out,
  output logic             n_out
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / BLOCK;
  localparam int LAST  = STAGES - 1;

  // One slice of the adder: BLOCK-bit generate/propagate groups, lookahead
  // carries between groups, local carries inside each group.
  // Returns {carry out of slice, carry into slice MSB, slice sum}.
  function automatic logic [SLICE+1:0] cla_slice(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             ci
  );
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] c;
    logic [NGRP:0]    gc;
    logic             grp_g;
    logic             grp_p;
    g     = x & y;
    p     = x ^ y;
    gc    = '0;
    c     = '0;
    gc[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int k = 0; k < BLOCK; k++) begin
        grp_g = g[j*BLOCK+k] | (p[j*BLOCK+k] & grp_g);
        grp_p = grp_p & p[j*BLOCK+k];
      end
      gc[j+1] = grp_g | (grp_p & gc[j]);
    end
    for (int i = 0; i < SLICE; i++) begin
      if (i % BLOCK == 0) begin
        c[i] = gc[i/BLOCK];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end
    return {gc[NGRP], c[SLICE-1], p ^ c};
  endfunction

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  // Stage registers: operands (consumed slices are simply ignored downstream),
  // partial sum, slice carry-out and valid bit.
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];
  logic             r_valid [STAGES];
  logic             r_v;
  logic             r_z;
  logic             r_n;

  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_s_in   [STAGES];
  logic [WIDTH-1:0] w_s_next [STAGES];
  logic             w_c_in   [STAGES];
  logic             w_v_in   [STAGES];
  logic [SLICE+1:0] w_res    [STAGES];

  logic [WIDTH-1:0] w_final;
  logic             w_cout;
  logic             w_cmsb;

  // Global stall: everything moves only when the output slot is free or draining.
  assign w_advance = !r_valid[LAST] || out_ready;
  assign in_ready  = w_advance;

  // Operand conditioning at issue: sub/sbc invert B; carry-in from op.
  assign w_b_eff = op[0] ? ~b : b;
  assign w_c0    = op[1] ? cin : op[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign w_a_in[gi] = a;
      assign w_b_in[gi] = w_b_eff;
      assign w_s_in[gi] = '0;
      assign w_c_in[gi] = w_c0;
      assign w_v_in[gi] = in_valid;
    end else begin : g_next
      assign w_a_in[gi] = r_a[gi-1];
      assign w_b_in[gi] = r_b[gi-1];
      assign w_s_in[gi] = r_sum[gi-1];
      assign w_c_in[gi] = r_carry[gi-1];
      assign w_v_in[gi] = r_valid[gi-1];
    end
    assign w_res[gi] = cla_slice(w_a_in[gi][gi*SLICE +: SLICE],
                                 w_b_in[gi][gi*SLICE +: SLICE],
                                 w_c_in[gi]);
    // Merge this stage's slice into the partial sum carried down the pipe.
    assign w_s_next[gi] = (w_s_in[gi] & ~(WIDTH'({SLICE{1'b1}}) << (gi*SLICE)))
                        | (WIDTH'(w_res[gi][SLICE-1:0]) << (gi*SLICE));
  end

  assign w_final = w_s_next[LAST];
  assign w_cout  = w_res[LAST][SLICE+1];
  assign w_cmsb  = w_res[LAST][SLICE];

  // Pipeline registers and final-stage flags; all hold while stalled.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int s = 0; s < STAGES; s++) begin
        r_a[s]     <= '0;
        r_b[s]     <= '0;
        r_sum[s]   <= '0;
        r_carry[s] <= 1'b0;
        r_valid[s] <= 1'b0;
      end
      r_v <= 1'b0;
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else if (w_advance) begin
      for (int s = 0; s < STAGES; s++) begin
        r_a[s]     <= w_a_in[s];
        r_b[s]     <= w_b_in[s];
        r_sum[s]   <= w_s_next[s];
        r_carry[s] <= w_res[s][SLICE+1];
        r_valid[s] <= w_v_in[s];
      end
      r_v <= w_cout ^ w_cmsb;
      r_z <= (w_final == '0);
      r_n <= w_final[WIDTH-1];
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign c_out     = r_carry[LAST];
  assign v_out     = r_v;
  assign z_out     = r_z;
  assign n_out     = r_n;

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Bench for pipelined_addsub_unit: three builds (STAGES=2, 1, 4) share one
// stimulus stream; each has its own scoreboard fed by an arithmetic model.
module tb_pipelined_addsub_unit;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        cin;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  ordy;
  logic [31:0] sm [3];
  logic [2:0]  cf;
  logic [2:0]  vf;
  logic [2:0]  zf;
  logic [2:0]  nf;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   lat_tab [3] = '{2, 1, 4};
  exp_t q [3][$];
  int   pop_cnt0    = 0;
  int   first_pop0  = 0;
  int   last_pop0   = 0;
  int   main_issued = 0;

  always #5 clk = ~clk;

  pipelined_addsub_unit #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut2 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]),
    .c_out(cf[0]), .v_out(vf[0]), .z_out(zf[0]), .n_out(nf[0])
  );

  pipelined_addsub_unit #(.WIDTH(32), .BLOCK(4), .STAGES(1)) u_dut1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]),
    .c_out(cf[1]), .v_out(vf[1]), .z_out(zf[1]), .n_out(nf[1])
  );

  pipelined_addsub_unit #(.WIDTH(32), .BLOCK(4), .STAGES(4)) u_dut4 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]),
    .c_out(cf[2]), .v_out(vf[2]), .z_out(zf[2]), .n_out(nf[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [1:0] o, input logic ci);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      ux;
    longint      uy;
    longint      sr;
    longint      cb;
    logic [63:0] srb;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    cb = ci ? 64'sd1 : 64'sd0;
    case (o)
      2'b00:   begin sr = sx + sy;            e.c = (ux + uy) > 64'sd4294967295;      end
      2'b01:   begin sr = sx - sy;            e.c = (ux >= uy);                       end
      2'b10:   begin sr = sx + sy + cb;       e.c = (ux + uy + cb) > 64'sd4294967295; end
      default: begin sr = sx - sy - (1 - cb); e.c = (ux >= uy + (1 - cb));            end
    endcase
    srb   = sr;
    e.sum = srb[31:0];
    e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z   = (e.sum == 32'd0);
    e.n   = e.sum[31];
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One cycle: sample mid-cycle, score transfers out/in for every build, advance.
  task automatic tick();
    exp_t e;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && ordy[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("u%0d_unexpected_out", k), 32'(ov[k]), 32'd0);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("u%0d_sum", k), sm[k], e.sum);
          chk($sformatf("u%0d_flags_cvzn", k), 32'({cf[k], vf[k], zf[k], nf[k]}),
              32'({e.c, e.v, e.z, e.n}));
          if (k == 0) begin
            chk("u0_latency_min", 32'((cyc - e.cyc) >= lat_tab[0]), 32'd1);
            if (pop_cnt0 == 0) first_pop0 = cyc;
            last_pop0 = cyc;
            pop_cnt0++;
          end else begin
            chk($sformatf("u%0d_latency", k), 32'(cyc - e.cyc), 32'(lat_tab[k]));
          end
        end
      end
      if (in_valid && ir[k]) begin
        e     = model(a, b, op, cin);
        e.cyc = cyc;
        q[k].push_back(e);
        if (k == 0) main_issued++;
      end
    end
    $display("[TB] cyc=%0d in_v=%0b a=%08h b=%08h op=%0d cin=%0b | u2 v=%0b s=%08h | u1 v=%0b | u4 v=%0b",
             cyc, in_valid, a, b, op, cin, ov[0], sm[0], ov[1], ov[2]);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [1:0] o, input logic ci,
                          input logic [31:0] es, input logic [3:0] ef);
    int lat;
    a = x; b = y; op = o; cin = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_sum"}, sm[0], es);
    chk({tag, "_flags_cvzn"}, 32'({cf[0], vf[0], zf[0], nf[0]}), 32'(ef));
    tick();
  endtask

  initial begin
    int guard;
    clr = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'b00; cin = 1'b0; ordy = 3'b111;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd1);
    chk("rst_sum", sm[0], 32'd0);
    chk("rst_flags", 32'({cf[0], vf[0], zf[0], nf[0]}), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(ir[0]), 32'd1);

    // Directed arithmetic cases, flags as {c,v,z,n}
    directed("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h8000_0000, 4'b0101);
    directed("sub_neg",  32'h0000_0005, 32'h0000_0007, 2'b01, 1'b0, 32'hFFFF_FFFE, 4'b0001);
    directed("sub_zero", 32'h0000_0005, 32'h0000_0005, 2'b01, 1'b0, 32'h0000_0000, 4'b1010);
    directed("adc_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0000, 4'b1010);
    directed("sbc_brw",  32'h0000_0010, 32'h0000_0001, 2'b11, 1'b0, 32'h0000_000E, 4'b1000);
    directed("sub_0_0",  32'h0000_0000, 32'h0000_0000, 2'b01, 1'b1, 32'h0000_0000, 4'b1010);
    directed("sbc_ovf",  32'h8000_0000, 32'h0000_0001, 2'b11, 1'b1, 32'h7FFF_FFFF, 4'b1100);
    repeat (6) tick();

    // Streaming: 4 back-to-back ops emerge in 4 consecutive cycles
    pop_cnt0 = 0;
    for (int i = 0; i < 4; i++) begin
      a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); cin = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("stream_count", 32'(pop_cnt0), 32'd4);
    chk("stream_span", 32'(last_pop0 - first_pop0), 32'd3);

    // Backpressure: stall 3 cycles with a result pending, then release
    pop_cnt0 = 0;
    for (int i = 0; i < 4; i++) begin
      a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); cin = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    a = $urandom; b = $urandom; op = 2'b01;
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(ir[0]), 32'd0);
      chk("stall_out_valid", 32'(ov[0]), 32'd1);
      if (q[0].size() > 0) chk("stall_sum_held", sm[0], q[0][0].sum);
      else chk("stall_queue_nonempty", 32'(q[0].size()), 32'd1);
      tick();
    end
    ordy[0] = 1'b1;
    in_valid = 1'b0;
    repeat (8) tick();
    chk("bp_no_loss_dup", 32'(pop_cnt0), 32'd4);
    chk("bp_queue_empty", 32'(q[0].size()), 32'd0);

    // Asynchronous clear with ops in flight
    for (int i = 0; i < 2; i++) begin
      a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); cin = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("clr_out_valid", 32'(ov[0]), 32'd0);
    chk("clr_sum", sm[0], 32'd0);
    chk("clr_flags", 32'({cf[0], vf[0], zf[0], nf[0]}), 32'd0);
    chk("clr_out_valid_s4", 32'(ov[2]), 32'd0);
    for (int k = 0; k < 3; k++) q[k].delete();
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", 32'(ir[0]), 32'd1);
    repeat (8) tick();

    // Randomized run against the model, random backpressure on the STAGES=2 build
    main_issued = 0;
    guard = 0;
    while (main_issued < 10000 && guard < 40000) begin
      a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); cin = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      ordy[0]  = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
    end
    chk("rand_issued_10k", 32'(main_issued >= 10000), 32'd1);
    in_valid = 1'b0;
    ordy = 3'b111;
    repeat (12) tick();
    for (int k = 0; k < 3; k++) chk($sformatf("u%0d_drained", k), 32'(q[k].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
